// File: rtl/note_pattern_pkg.sv
// rtl/note_pattern_pkg.sv - shared types, pattern codes and note mapping for note_pattern_ctrl (MANUAL state under NOTE_PATTERN_CTRL_MANUAL_EN)
package note_pattern_pkg;

`ifdef NOTE_PATTERN_CTRL_MANUAL_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CAND   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_MANUAL = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CAND   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;
`endif

    localparam logic [1:0] PAT_STRIPES = 2'd0;
    localparam logic [1:0] PAT_HYPER   = 2'd1;
    localparam logic [1:0] PAT_CIRCLE  = 2'd2;
    localparam logic [1:0] PAT_DEFAULT = 2'd3;

    localparam logic [3:0] NOTE_NONE = 4'hF;

    function automatic logic [1:0] note_to_pattern(input logic [3:0] idx);
        logic [3:0] rem;
        rem = idx % 4'd3;
        return rem[1:0];
    endfunction

endpackage

// File: rtl/note_pattern_ctrl_key_edge.sv
// rtl/note_pattern_ctrl_key_edge.sv - key_edge_detect: 2-flop key synchronizer with OR-reduced rising-edge pulse
module key_edge_detect #(
    parameter int w_key = 4
) (
    input  logic             clk,   // system clock
    input  logic             rst,   // synchronous, active-high
    input  logic [w_key-1:0] key,   // raw asynchronous push-buttons
    output logic             hit    // one-cycle pulse: some key just went high
);
    logic [w_key-1:0] sync1;
    logic [w_key-1:0] sync2;
    logic [w_key-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Combinational so the FSM acts on the third edge after the key changes.
    assign hit = |(sync2 & ~prev);

endmodule

// File: rtl/note_pattern_ctrl.sv
// rtl/note_pattern_ctrl.sv - debounced note-to-pattern FSM with animation tick; NOTE_PATTERN_CTRL_MANUAL_EN adds key override
module note_pattern_ctrl
    import note_pattern_pkg::*;
#(
    parameter int clk_mhz     = 50,
    parameter int w_key       = 4,
    parameter int confirm_cnt = 3,
    parameter int hold_ms     = 500,
    parameter int w_tick      = 20
) (
    input  logic             clk,       // single clock, posedge
    input  logic             rst,       // synchronous, active-high
    input  logic             note_vld,  // one-cycle note detect pulse
    input  logic [3:0]       note_idx,  // 0..11 valid
    input  logic [w_key-1:0] key,       // raw push-buttons
    output logic [1:0]       pattern,   // graphics pattern select
    output logic [3:0]       note_out,  // committed note, NOTE_NONE if none
    output logic             locked,    // LOCKED or MANUAL
    output logic             tick       // animation step enable
);
    localparam int            HOLD_CYC  = clk_mhz * 1000 * hold_ms;
    localparam int            TW        = $clog2(HOLD_CYC) + 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC);
    localparam logic [3:0]    CONFIRM   = 4'(confirm_cnt);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cand;
    logic [3:0]        cand_nx;
    logic [3:0]        match;
    logic [3:0]        match_nx;
    logic [3:0]        note_nx;
    logic [1:0]        pat_nx;
    logic              locked_nx;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_nx;
    logic [w_tick-1:0] presc;
    logic              note_ok;
    logic              note_take;
    logic              expire;
    logic              fast;

    assign note_ok = note_vld && (note_idx <= 4'd11);
    // Fires on the cycle the counter would step down to zero.
    assign expire  = (state != ST_IDLE) && (timer <= TW'(1));

`ifdef NOTE_PATTERN_CTRL_MANUAL_EN
    logic key_hit;

    key_edge_detect #(
        .w_key(w_key)
    ) u_key_edge (
        .clk(clk),
        .rst(rst),
        .key(key),
        .hit(key_hit)
    );

    assign note_take = note_ok && (state != ST_MANUAL);
    assign fast      = (state == ST_LOCKED) || (state == ST_MANUAL);
    assign locked_nx = (state_nx == ST_LOCKED) || (state_nx == ST_MANUAL);
`else
    logic unused_key;
    assign unused_key = ^key;
    assign note_take  = note_ok;
    assign fast       = (state == ST_LOCKED);
    assign locked_nx  = (state_nx == ST_LOCKED);
`endif

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        match_nx = match;
        pat_nx   = pattern;
        note_nx  = note_out;
        timer_nx = (state == ST_IDLE) ? timer : timer - TW'(1);
`ifdef NOTE_PATTERN_CTRL_MANUAL_EN
        if (key_hit) begin
            state_nx = ST_MANUAL;
            pat_nx   = pattern + 2'd1;
            note_nx  = NOTE_NONE;
            timer_nx = HOLD_LOAD;
        end else
`endif
        if (note_take) begin
            // A valid note always reloads, so it overrides a same-cycle expiry.
            timer_nx = HOLD_LOAD;
            if (!((state == ST_LOCKED) && (note_idx == note_out))) begin
                cand_nx  = note_idx;
                match_nx = ((state == ST_CAND) && (note_idx == cand)) ? match + 4'd1 : 4'd1;
                if (match_nx >= CONFIRM) begin
                    state_nx = ST_LOCKED;
                    pat_nx   = note_to_pattern(note_idx);
                    note_nx  = note_idx;
                end else begin
                    state_nx = ST_CAND;
                end
            end
        end else if (expire) begin
            state_nx = ST_IDLE;
            // An unconfirmed candidate timing out leaves the last committed display alone.
            if (state != ST_CAND) begin
                pat_nx  = PAT_DEFAULT;
                note_nx = NOTE_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cand     <= '0;
            match    <= '0;
            timer    <= '0;
            pattern  <= PAT_DEFAULT;
            note_out <= NOTE_NONE;
            locked   <= 1'b0;
            presc    <= '0;
        end else begin
            state    <= state_nx;
            cand     <= cand_nx;
            match    <= match_nx;
            timer    <= timer_nx;
            pattern  <= pat_nx;
            note_out <= note_nx;
            locked   <= locked_nx;
            presc    <= presc + w_tick'(1);
        end
    end

    // Locked animation runs twice as fast by ignoring the prescaler MSB.
    assign tick = fast ? (&presc[w_tick-2:0]) : (&presc);

endmodule
